// File: rtl/sdram_cmd_responder.sv
// ---------------------------------------------------------------------------
// sdram_cmd_responder
//
// Single-chip x16 SDR SDRAM responder. Decodes the command bus produced by
// sdram_nes_controller and answers it like a real device: per-bank open rows,
// mode register (burst length / CAS latency), sequential wrapped bursts,
// write and read DQM, and a small on-chip backing array. Protocol and timing
// violations are collected as sticky error flags.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sdram_cke         clock enable; when low commands are ignored and
//                     bursts / read pipeline hold
//   sdram_cs_n        chip select (high = NOP)
//   sdram_ras_n/cas_n/we_n  command bits
//   sdram_bs          bank select
//   sdram_a           row / column / mode address, a[10] = all-bank / AP
//   sdram_dqm         byte masks, [0] = low byte
//   dq_in             write data from the controller
//   dq_out, dq_oe     read data and responder bus-drive enable
//   mode_set          LOAD MODE seen since reset
//   err               sticky violation flags:
//                     [0] rd/wr before mode, [1] ACTIVE to open bank,
//                     [2] rd/wr to closed bank, [3] tRCD, [4] refresh with
//                     open bank, [5] illegal mode field
//   refresh_cnt       saturating REFRESH count
// ---------------------------------------------------------------------------
module sdram_cmd_responder #(
    parameter int unsigned COL_DEPTH = 9,
    parameter int unsigned ROW_DEPTH = 13,
    parameter int unsigned MEM_AW    = 12,
    parameter int unsigned T_RCD     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_bs,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        mode_set,
    output logic [5:0]  err,
    output logic [15:0] refresh_cnt
);

    localparam int unsigned TrcdW = (T_RCD > 1) ? $clog2(T_RCD) : 1;
    localparam logic [TrcdW-1:0] TrcdLoad = TrcdW'(T_RCD - 1);
    localparam logic [TrcdW-1:0] TrcdOne = TrcdW'(1);
    localparam logic [COL_DEPTH-1:0] ColOne = COL_DEPTH'(1);

    typedef enum logic [2:0] {
        CmdLoadMode  = 3'b000,
        CmdRefresh   = 3'b001,
        CmdPrecharge = 3'b010,
        CmdActive    = 3'b011,
        CmdWrite     = 3'b100,
        CmdRead      = 3'b101,
        CmdBst       = 3'b110,
        CmdNop       = 3'b111
    } cmd_e;

    // Bank state
    logic [3:0]           bank_open_q;
    logic [ROW_DEPTH-1:0] bank_row_q [4];
    logic [TrcdW-1:0]     trcd_q [4];

    // Mode register
    logic [3:0] bl_q;   // burst length as a beat count (1, 2, 4, 8)
    logic       cl3_q;  // 1 = CAS latency 3, 0 = CAS latency 2

    // Burst in progress (state for the next beat)
    logic                 burst_act_q;
    logic                 burst_wr_q;
    logic                 burst_ap_q;
    logic [1:0]           burst_bank_q;
    logic [ROW_DEPTH-1:0] burst_row_q;
    logic [COL_DEPTH-1:0] burst_col_q;
    logic [3:0]           burst_left_q;

    // Read pipeline: stage 0 feeds the output at CL2, stage 1 at CL3
    logic        p0_v_q, p1_v_q;
    logic [15:0] p0_d_q, p1_d_q;
    logic [1:0]  dqm_q;

    logic [15:0] mem [2**MEM_AW] = '{default: 16'h0000};

    // Command decode
    cmd_e cmd;
    logic cmd_en, is_rw, rw_ok, is_bst, beat_cont, wr_cancel;

    assign cmd_en    = sdram_cke & ~sdram_cs_n;
    assign cmd       = cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});
    assign is_rw     = cmd_en & ((cmd == CmdRead) | (cmd == CmdWrite));
    assign rw_ok     = is_rw & bank_open_q[sdram_bs];
    assign is_bst    = cmd_en & (cmd == CmdBst);
    // A fresh READ/WRITE or BURST TERMINATE pre-empts the pending beat.
    assign beat_cont = burst_act_q & sdram_cke & ~rw_ok & ~is_bst;
    assign wr_cancel = rw_ok & (cmd == CmdWrite);

    // Beat issued at this edge, either from a new command or a running burst
    logic                 beat_vld, beat_wr, beat_ap, beat_last, ap_close;
    logic [1:0]           beat_bank;
    logic [ROW_DEPTH-1:0] beat_row;
    logic [COL_DEPTH-1:0] beat_col, beat_col_next, col_mask;
    logic [3:0]           beat_left;
    logic [MEM_AW-1:0]    beat_addr;
    logic [15:0]          rd_data;

    always_comb begin
        beat_vld  = 1'b0;
        beat_wr   = 1'b0;
        beat_ap   = 1'b0;
        beat_bank = sdram_bs;
        beat_row  = bank_row_q[sdram_bs];
        beat_col  = sdram_a[COL_DEPTH-1:0];
        beat_left = bl_q - 4'd1;
        if (rw_ok) begin
            beat_vld = 1'b1;
            beat_wr  = (cmd == CmdWrite);
            beat_ap  = sdram_a[10];
        end else if (beat_cont) begin
            beat_vld  = 1'b1;
            beat_wr   = burst_wr_q;
            beat_ap   = burst_ap_q;
            beat_bank = burst_bank_q;
            beat_row  = burst_row_q;
            beat_col  = burst_col_q;
            beat_left = burst_left_q - 4'd1;
        end
    end

    // Sequential column wrap inside the BL-aligned block
    assign col_mask      = COL_DEPTH'(bl_q - 4'd1);
    assign beat_col_next = (beat_col & ~col_mask) | ((beat_col + ColOne) & col_mask);
    assign beat_addr     = MEM_AW'({beat_row, beat_bank, beat_col});
    assign beat_last     = (beat_left == 4'd0);
    assign ap_close      = beat_vld & beat_last & beat_ap;
    assign rd_data       = mem[beat_addr];

    // Mode field decode
    logic       mode_legal;
    logic [3:0] mode_bl;

    assign mode_legal = ~sdram_a[2] & (sdram_a[6:5] == 2'b01);
    assign mode_bl    = 4'd1 << sdram_a[1:0];

    // Output stage source
    logic        out_v;
    logic [15:0] out_d;

    assign out_v = cl3_q ? p1_v_q : p0_v_q;
    assign out_d = cl3_q ? p1_d_q : p0_d_q;

    always_ff @(posedge clk) begin
        if (!rst && beat_vld && beat_wr) begin
            if (!sdram_dqm[0]) mem[beat_addr][7:0]  <= dq_in[7:0];
            if (!sdram_dqm[1]) mem[beat_addr][15:8] <= dq_in[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_out       <= 16'h0000;
            dq_oe        <= 1'b0;
            mode_set     <= 1'b0;
            err          <= 6'b000000;
            refresh_cnt  <= 16'h0000;
            bank_open_q  <= 4'b0000;
            for (int b = 0; b < 4; b++) begin
                bank_row_q[b] <= '0;
                trcd_q[b]     <= '0;
            end
            bl_q         <= 4'd1;
            cl3_q        <= 1'b0;
            burst_act_q  <= 1'b0;
            burst_wr_q   <= 1'b0;
            burst_ap_q   <= 1'b0;
            burst_bank_q <= 2'b00;
            burst_row_q  <= '0;
            burst_col_q  <= '0;
            burst_left_q <= 4'd0;
            p0_v_q       <= 1'b0;
            p1_v_q       <= 1'b0;
            p0_d_q       <= 16'h0000;
            p1_d_q       <= 16'h0000;
            dqm_q        <= 2'b00;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (trcd_q[b] != '0) trcd_q[b] <= trcd_q[b] - TrcdOne;
            end

            if (sdram_cke) begin
                // Burst bookkeeping
                if (beat_vld) begin
                    burst_act_q  <= ~beat_last;
                    burst_wr_q   <= beat_wr;
                    burst_ap_q   <= beat_ap;
                    burst_bank_q <= beat_bank;
                    burst_row_q  <= beat_row;
                    burst_col_q  <= beat_col_next;
                    burst_left_q <= beat_left;
                end else begin
                    burst_act_q <= 1'b0;
                end
                // Auto-precharge lands before any command on this edge.
                if (ap_close) bank_open_q[beat_bank] <= 1'b0;

                // Read pipeline and output stage
                p0_v_q <= beat_vld & ~beat_wr;
                p0_d_q <= rd_data;
                p1_v_q <= p0_v_q & ~wr_cancel;
                p1_d_q <= p0_d_q;
                dqm_q  <= sdram_dqm;
                if (wr_cancel || !out_v) begin
                    dq_oe  <= 1'b0;
                    dq_out <= 16'h0000;
                end else begin
                    dq_oe  <= ~&dqm_q;
                    dq_out <= {dqm_q[1] ? 8'h00 : out_d[15:8], dqm_q[0] ? 8'h00 : out_d[7:0]};
                end

                if (cmd_en) begin
                    unique case (cmd)
                        CmdLoadMode: begin
                            mode_set <= 1'b1;
                            if (mode_legal) begin
                                bl_q  <= mode_bl;
                                cl3_q <= sdram_a[4];
                            end else begin
                                bl_q   <= 4'd1;
                                cl3_q  <= 1'b0;
                                err[5] <= 1'b1;
                            end
                        end
                        CmdRefresh: begin
                            if (refresh_cnt != 16'hFFFF) refresh_cnt <= refresh_cnt + 16'd1;
                            if (|bank_open_q) err[4] <= 1'b1;
                        end
                        CmdPrecharge: begin
                            if (sdram_a[10]) bank_open_q <= 4'b0000;
                            else             bank_open_q[sdram_bs] <= 1'b0;
                        end
                        CmdActive: begin
                            // A bank closing by auto-precharge on this edge counts as idle.
                            if (bank_open_q[sdram_bs] && !(ap_close && beat_bank == sdram_bs))
                                err[1] <= 1'b1;
                            bank_open_q[sdram_bs] <= 1'b1;
                            bank_row_q[sdram_bs]  <= sdram_a[ROW_DEPTH-1:0];
                            trcd_q[sdram_bs]      <= TrcdLoad;
                        end
                        CmdRead, CmdWrite: begin
                            if (!mode_set) err[0] <= 1'b1;
                            if (!bank_open_q[sdram_bs])       err[2] <= 1'b1;
                            else if (trcd_q[sdram_bs] != '0)  err[3] <= 1'b1;
                        end
                        CmdBst, CmdNop: begin
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
module tb_sdram_cmd_responder;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_BST = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_bs;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_dqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        mode_set;
    logic [5:0]  err;
    logic [15:0] refresh_cnt;

    int vectors = 0;
    int miscompares = 0;

    sdram_cmd_responder dut (
        .clk         (clk),
        .rst         (rst),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_bs    (sdram_bs),
        .sdram_a     (sdram_a),
        .sdram_dqm   (sdram_dqm),
        .dq_in       (dq_in),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .mode_set    (mode_set),
        .err         (err),
        .refresh_cnt (refresh_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_bus();
        sdram_cs_n = 1'b1;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b111;
        sdram_bs  = 2'b00;
        sdram_a   = 13'h0000;
        sdram_dqm = 2'b00;
        dq_in     = 16'h0000;
    endtask

    task automatic nop();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single edge, then return the bus to idle.
    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                         input logic [15:0] d, input logic [1:0] m);
        sdram_cs_n = 1'b0;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        sdram_bs  = b;
        sdram_a   = addr;
        dq_in     = d;
        sdram_dqm = m;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic test_reset();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL reset_dq_oe: got %b want 0", dq_oe); end
        vectors++; if (dq_out !== 16'h0000) begin miscompares++; $display("FAIL reset_dq_out: got %h want 0000", dq_out); end
        vectors++; if (mode_set !== 1'b0) begin miscompares++; $display("FAIL reset_mode_set: got %b want 0", mode_set); end
        vectors++; if (err !== 6'h00) begin miscompares++; $display("FAIL reset_err: got %h want 00", err); end
        vectors++; if (refresh_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_refresh_cnt: got %h want 0000", refresh_cnt); end
    endtask

    task automatic test_basic_rw();
        issue(C_LMR, 2'd0, 13'h020, 16'h0, 2'b00);   // CL2 BL1
        issue(C_ACT, 2'd1, 13'h055, 16'h0, 2'b00);
        nop();
        nop();
        issue(C_WR, 2'd1, 13'h010, 16'hBEEF, 2'b00);
        issue(C_RD, 2'd1, 13'h010, 16'h0, 2'b00);
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL basic_oe_at_cmd: got %b want 0", dq_oe); end
        nop();
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'hBEEF) begin miscompares++; $display("FAIL basic_read: got oe=%b %h want oe=1 beef", dq_oe, dq_out); end
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL basic_oe_release: got %b want 0", dq_oe); end
        vectors++; if (mode_set !== 1'b1) begin miscompares++; $display("FAIL basic_mode_set: got %b want 1", mode_set); end
        vectors++; if (err !== 6'h00) begin miscompares++; $display("FAIL basic_err: got %h want 00", err); end
    endtask

    task automatic test_burst_wrap();
        logic [15:0] exp_q [4];
        exp_q = '{16'h3333, 16'h4444, 16'h1111, 16'h2222};
        issue(C_LMR, 2'd0, 13'h032, 16'h0, 2'b00);   // CL3 BL4
        // Block 0x0C..0x0F gets 1111..4444; reading from 0x0E must wrap.
        issue(C_WR, 2'd1, 13'h00C, 16'h1111, 2'b00);
        dq_in = 16'h2222; nop();
        dq_in = 16'h3333; nop();
        dq_in = 16'h4444; nop();
        dq_in = 16'h0000;
        issue(C_RD, 2'd1, 13'h00E, 16'h0, 2'b00);
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL wrap_lat0: got %b want 0", dq_oe); end
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL wrap_lat1: got %b want 0", dq_oe); end
        for (int i = 0; i < 4; i++) begin
            nop();
            vectors++;
            if (dq_oe !== 1'b1 || dq_out !== exp_q[i]) begin
                miscompares++;
                $display("FAIL wrap_beat%0d: got oe=%b %h want oe=1 %h", i, dq_oe, dq_out, exp_q[i]);
            end
        end
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL wrap_end: got %b want 0", dq_oe); end
    endtask

    task automatic test_burst_terminate();
        issue(C_LMR, 2'd0, 13'h023, 16'h0, 2'b00);   // CL2 BL8
        issue(C_RD, 2'd1, 13'h00C, 16'h0, 2'b00);
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL bst_lat0: got %b want 0", dq_oe); end
        nop();
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'h1111) begin miscompares++; $display("FAIL bst_beat0: got oe=%b %h want oe=1 1111", dq_oe, dq_out); end
        nop();
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'h2222) begin miscompares++; $display("FAIL bst_beat1: got oe=%b %h want oe=1 2222", dq_oe, dq_out); end
        issue(C_BST, 2'd0, 13'h000, 16'h0, 2'b00);
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'h3333) begin miscompares++; $display("FAIL bst_beat2: got oe=%b %h want oe=1 3333", dq_oe, dq_out); end
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL bst_stop: got %b want 0", dq_oe); end
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL bst_stop2: got %b want 0", dq_oe); end
    endtask

    task automatic test_dqm();
        issue(C_LMR, 2'd0, 13'h020, 16'h0, 2'b00);   // CL2 BL1
        issue(C_WR, 2'd1, 13'h020, 16'hA5C3, 2'b01); // low byte masked over zero
        issue(C_RD, 2'd1, 13'h020, 16'h0, 2'b00);
        nop();
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'hA500) begin miscompares++; $display("FAIL dqm_write: got oe=%b %h want oe=1 a500", dq_oe, dq_out); end
        issue(C_RD, 2'd1, 13'h020, 16'h0, 2'b11);
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL dqm_read_both: got %b want 0", dq_oe); end
        issue(C_RD, 2'd1, 13'h010, 16'h0, 2'b10);
        nop();
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'h00EF) begin miscompares++; $display("FAIL dqm_read_hi: got oe=%b %h want oe=1 00ef", dq_oe, dq_out); end
    endtask

    task automatic test_errors();
        issue(C_RD, 2'd2, 13'h000, 16'h0, 2'b00);
        vectors++; if (err !== 6'h04) begin miscompares++; $display("FAIL err_closed_bank: got %h want 04", err); end
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL closed_bank_no_data: got %b want 0", dq_oe); end
        issue(C_ACT, 2'd2, 13'h007, 16'h0, 2'b00);
        issue(C_RD, 2'd2, 13'h000, 16'h0, 2'b00);
        vectors++; if (err !== 6'h0C) begin miscompares++; $display("FAIL err_trcd: got %h want 0c", err); end
        nop();
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'h0000) begin miscompares++; $display("FAIL trcd_still_reads: got oe=%b %h want oe=1 0000", dq_oe, dq_out); end
        issue(C_REF, 2'd0, 13'h000, 16'h0, 2'b00);
        vectors++; if (err !== 6'h1C) begin miscompares++; $display("FAIL err_refresh_open: got %h want 1c", err); end
        vectors++; if (refresh_cnt !== 16'h0001) begin miscompares++; $display("FAIL refresh_cnt: got %h want 0001", refresh_cnt); end
        issue(C_ACT, 2'd2, 13'h007, 16'h0, 2'b00);
        vectors++; if (err !== 6'h1E) begin miscompares++; $display("FAIL err_act_open: got %h want 1e", err); end
        issue(C_LMR, 2'd0, 13'h032, 16'h0, 2'b00);   // legal CL3 BL4
        issue(C_LMR, 2'd0, 13'h041, 16'h0, 2'b00);   // CL field 100 is illegal
        vectors++; if (err !== 6'h3E) begin miscompares++; $display("FAIL err_mode: got %h want 3e", err); end
        // Fallback must be CL2 / BL1.
        issue(C_RD, 2'd1, 13'h010, 16'h0, 2'b00);
        nop();
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'hBEEF) begin miscompares++; $display("FAIL mode_fallback_cl: got oe=%b %h want oe=1 beef", dq_oe, dq_out); end
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL mode_fallback_bl: got %b want 0", dq_oe); end
    endtask

    task automatic test_reset_mid_burst();
        issue(C_LMR, 2'd0, 13'h023, 16'h0, 2'b00);   // CL2 BL8
        issue(C_RD, 2'd1, 13'h00C, 16'h0, 2'b00);
        nop();
        vectors++; if (dq_oe !== 1'b1) begin miscompares++; $display("FAIL pre_reset_oe: got %b want 1", dq_oe); end
        rst = 1'b1;
        #1;
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL async_reset_oe: got %b want 0", dq_oe); end
        vectors++; if (err !== 6'h00) begin miscompares++; $display("FAIL async_reset_err: got %h want 00", err); end
        vectors++; if (refresh_cnt !== 16'h0000 || mode_set !== 1'b0) begin miscompares++; $display("FAIL async_reset_misc: got cnt=%h mode=%b want 0000 0", refresh_cnt, mode_set); end
        nop();
        rst = 1'b0;
        nop();
        issue(C_RD, 2'd1, 13'h00C, 16'h0, 2'b00);
        vectors++; if (err !== 6'h05) begin miscompares++; $display("FAIL post_reset_err: got %h want 05", err); end
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL post_reset_no_data: got %b want 0", dq_oe); end
    endtask

    task automatic test_auto_precharge();
        issue(C_LMR, 2'd0, 13'h020, 16'h0, 2'b00);
        issue(C_ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        nop();
        nop();
        issue(C_WR, 2'd0, 13'h401, 16'h1234, 2'b00); // a[10] closes bank 0 after the beat
        issue(C_ACT, 2'd0, 13'h000, 16'h0, 2'b00);
        vectors++; if (err !== 6'h05) begin miscompares++; $display("FAIL ap_closed_bank: got %h want 05", err); end
        nop();
        nop();
        issue(C_RD, 2'd0, 13'h001, 16'h0, 2'b00);
        nop();
        vectors++; if (dq_oe !== 1'b1 || dq_out !== 16'h1234) begin miscompares++; $display("FAIL ap_write_data: got oe=%b %h want oe=1 1234", dq_oe, dq_out); end
    endtask

    task automatic test_cke_hold();
        sdram_cke = 1'b0;
        issue(C_RD, 2'd0, 13'h001, 16'h0, 2'b00);
        sdram_cke = 1'b1;
        nop();
        vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL cke_ignores_cmd: got %b want 0", dq_oe); end
    endtask

    initial begin
        rst = 1'b1;
        sdram_cke = 1'b1;
        idle_bus();
        #12;
        test_reset();
        rst = 1'b0;
        nop();
        test_basic_rw();
        test_burst_wrap();
        test_burst_terminate();
        test_dqm();
        test_errors();
        test_reset_mid_burst();
        test_auto_precharge();
        test_cke_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
